// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencer for the 8-bit datapath. Optional macro CTRL_COND_JUMP_EN enables conditional jumps.
// Ports: clk, reset (sync, active-high), progData[7:0] (byte at pc), aIsZero, flagCarry (ALU status) ->
// pc[7:0], doSubtract, assertBarE, assertBarM, loadBarA/B/X (active-low), halted.
module ctrl_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] progData,
  input  logic       aIsZero,
  input  logic       flagCarry,
  output logic [7:0] pc,
  output logic       doSubtract,
  output logic       assertBarE,
  output logic       assertBarM,
  output logic       loadBarA,
  output logic       loadBarB,
  output logic       loadBarX,
  output logic       halted
);
  typedef enum logic [1:0] {FETCH, OPERAND, EXEC, HALT} state_t;
  state_t state, state_n;
  logic [7:0] ir, ir_n, pc_n;
  logic f_alu, f_ld, f_jmp, is_ld, take, exec, ldi, ld_en;
  assign f_alu = progData[7:6] == 2'b00 && progData[4:2] == 3'b000;
  assign f_ld  = progData[7:6] == 2'b01 && progData[5:2] == 4'b0000;
  assign f_jmp = progData[7:6] == 2'b10 && progData[5:3] == 3'b000;
  assign is_ld = ir[7:6] == 2'b01;
`ifdef CTRL_COND_JUMP_EN
  assign take = ir[2:0] == 3'd0 || (ir[2:0] == 3'd1 && aIsZero) || (ir[2:0] == 3'd2 && !aIsZero) ||
                (ir[2:0] == 3'd3 && flagCarry) || (ir[2:0] == 3'd4 && !flagCarry);
`else
  assign take = ir[2:0] == 3'd0;
`endif
  // Strobes are suppressed during the reset cycle so an interrupted instruction never loads.
  assign exec  = state == EXEC && !reset;
  assign ldi   = state == OPERAND && is_ld && !reset;
  assign ld_en = exec || ldi;
  assign doSubtract = exec && ir[5];
  assign assertBarE = !exec;
  assign assertBarM = !ldi;
  assign loadBarA   = !(ld_en && ir[1:0] == 2'd0);
  assign loadBarB   = !(ld_en && ir[1:0] == 2'd1);
  assign loadBarX   = !(ld_en && ir[1:0] == 2'd2);
  assign halted     = state == HALT;
  always_comb begin
    state_n = state;
    ir_n = ir;
    pc_n = pc;
    case (state)
      FETCH: begin
        ir_n = progData;
        pc_n = pc + 8'd1;
        state_n = f_alu ? EXEC : (f_ld || f_jmp) ? OPERAND : progData[7:6] == 2'b11 ? HALT : FETCH;
      end
      OPERAND: begin
        pc_n = (!is_ld && take) ? progData : pc + 8'd1;
        state_n = FETCH;
      end
      EXEC: state_n = FETCH;
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= 8'h00;
      ir <= 8'h00;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
    end
  end
endmodule
